// File: rtl/one_port_ram_pkg.sv
// one_port_ram_pkg: shared defaults for the single-port synchronous RAM.
// Optional output pipeline stage is selected with ONE_PORT_RAM_OUTREG_EN.
package one_port_ram_pkg;
    localparam int ADDR_WIDTH_DEF = 13;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 2 ** ADDR_WIDTH_DEF;
    localparam logic [DATA_WIDTH_DEF-1:0] RST_VAL = '0;
endpackage

// File: rtl/one_port_ram_array.sv
// one_port_ram_array: reset-free storage with synchronous read-first output,
// kept bare so synthesis maps it straight onto a block RAM.
module one_port_ram_array
    import one_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_q;

    // Unknown we must never write, hence the case-equality test.
    always_ff @(posedge clk) begin
        if (we === 1'b1) mem[addr] <= din;
        rd_q <= mem[addr];
    end

    assign rd_data = rd_q;
endmodule

// File: rtl/one_port_ram_sync.sv
// one_port_ram_sync: single-port RAM with asynchronously reset read data.
// Define ONE_PORT_RAM_OUTREG_EN for an extra output register (2-cycle reads).
module one_port_ram_sync
    import one_port_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam logic [DATA_WIDTH-1:0] RST_WORD = DATA_WIDTH'(RST_VAL);

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hold_d, hold_q;

    one_port_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk    (clk),
        .addr   (addr),
        .we     (we),
        .din    (din),
        .rd_data(rd_data)
    );

    // The RAM read register has no reset; hold_q masks it from reset assertion
    // until the first edge after release, which is also the first valid read.
    always_comb hold_d = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= 1'b1;
        else hold_q <= hold_d;
    end

`ifdef ONE_PORT_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] out_d, out_q;

    always_comb out_d = hold_q ? RST_WORD : rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q <= RST_WORD;
        else out_q <= out_d;
    end

    assign dout = out_q;
`else
    assign dout = hold_q ? RST_WORD : rd_data;
`endif
endmodule

// File: tb/tb_one_port_ram_sync.sv
// tb_one_port_ram_sync: directed vectors for one_port_ram_sync, either build.
module tb_one_port_ram_sync;
    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] addr;
    logic        we;
    logic [15:0] din;
    logic [15:0] dout;
    int          vectors = 0;
    int          fails = 0;
    logic [15:0] prev_exp = 16'h0000;

    one_port_ram_sync dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] exp_v);
        vectors++;
        assert (dout === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, dout, exp_v);
        end
    endtask

    // exp_v is the value the single read register would show after this edge;
    // with the output stage the bench expects the previous step's value instead.
    task automatic step(input string tag, input logic [15:0] exp_v);
        @(posedge clk);
        #1;
`ifdef ONE_PORT_RAM_OUTREG_EN
        chk(tag, prev_exp);
        prev_exp = exp_v;
`else
        chk(tag, exp_v);
`endif
    endtask

    task automatic drive(input logic w, input logic [12:0] a, input logic [15:0] d);
        we = w;
        addr = a;
        din = d;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 13'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) step("reset_hold", 16'h0000);
        reset = 1'b0;
        step("reset_release_mem0", 16'h0000);
        drive(1'b1, 13'h0000, 16'h0001);
        step("wr0_readfirst", 16'h0000);
        drive(1'b1, 13'h0001, 16'hFFFF);
        step("wr1_readfirst", 16'h0000);
        drive(1'b0, 13'h0000, 16'h0000);
        step("rd0", 16'h0001);
        drive(1'b0, 13'h0001, 16'h0000);
        step("rd1", 16'hFFFF);
        drive(1'b1, 13'h0005, 16'h1234);
        step("wr5_init", 16'h0000);
        drive(1'b1, 13'h0005, 16'hABCD);
        step("rdw5_old", 16'h1234);
        drive(1'b0, 13'h0005, 16'h0000);
        step("rd5_new", 16'hABCD);
        drive(1'b1, 13'h1FFF, 16'hA5A5);
        step("wr_top", 16'h0000);
        drive(1'b1, 13'h0000, 16'h5A5A);
        step("wr_bottom_old", 16'h0001);
        drive(1'b0, 13'h1FFF, 16'h0000);
        step("rd_top", 16'hA5A5);
        drive(1'b0, 13'h0000, 16'h0000);
        step("rd_bottom", 16'h5A5A);
        drive(1'b0, 13'h0001, 16'h0000);
        step("rd1_no_alias", 16'hFFFF);
        drive(1'bx, 13'h0001, 16'h0000);
        step("we_x_read", 16'hFFFF);
        drive(1'b0, 13'h0001, 16'h0000);
        step("we_x_no_write", 16'hFFFF);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 16'h0000);
        prev_exp = 16'h0000;
        step("reset_mid", 16'h0000);
        drive(1'b1, 13'h0007, 16'h7777);
        step("wr_in_reset", 16'h0000);
        drive(1'b0, 13'h0001, 16'h0000);
        reset = 1'b0;
        step("rd1_after_reset", 16'hFFFF);
        drive(1'b0, 13'h0007, 16'h0000);
        step("rd7_written_in_reset", 16'h7777);
        step("hold7", 16'h7777);
        drive(1'b0, 13'h0001, 16'h0000);
        step("rd1_again", 16'hFFFF);
        step("flush", 16'hFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
